// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: shares one LCD command engine between a CPU command FIFO and
// a single-entry game-engine slot. Grants are round-robin. Each command is held
// until the controller reports completion or the watchdog expires. The engine
// is then cleared and released before the next grant.
module lcd_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TO_W       = 20
) (
  input  logic                        clk,
  input  logic                        RSTn,
  input  logic                        cpu_valid,
  input  logic [30:0]                 cpu_cmd,
  output logic                        cpu_ready,
  input  logic                        eng_valid,
  input  logic [30:0]                 eng_cmd,
  output logic                        eng_ready,
  output logic [31:0]                 LCD_REG,
  output logic                        rstn_LCD_en,
  input  logic                        LCD_RUN_FINISH,
  output logic                        busy,
  output logic                        done_pulse,
  output logic                        done_src,
  output logic                        timeout_err,
  input  logic                        err_clr,
  output logic [$clog2(FIFO_DEPTH):0] cpu_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  // One below the all-ones terminal count: the increment from here reaches 2^TO_W-1.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CLEAR, S_GAP} state_e;

  state_e state_q, state_d;

  // CPU FIFO storage and control
  logic [30:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          cpu_full, cpu_empty, cpu_push, cpu_pop;

  // Engine slot
  logic          eng_full_q;
  logic [30:0]   eng_cmd_q;
  logic          eng_push;

  // Arbitration and command tracking
  logic          grant_cpu, grant_eng;
  logic          last_grant_q, last_grant_d;   // 1 = engine granted last
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic          wd_expire;

  // Registered outputs
  logic [31:0]   lcd_reg_q, lcd_reg_d;
  logic          rstn_en_q, rstn_en_d;
  logic          done_pulse_q, done_pulse_d;
  logic          done_src_q, done_src_d;
  logic          timeout_err_q, timeout_err_d;

  // Full is judged on the pre-pop level, so a push into a full FIFO is refused
  // even when a grant drains an entry in the same cycle.
  assign cpu_full  = (level_q == FULL_LVL);
  assign cpu_empty = (level_q == '0);
  assign cpu_ready = !cpu_full;
  assign cpu_push  = cpu_valid && !cpu_full;
  assign cpu_pop   = grant_cpu;

  assign eng_ready = !eng_full_q;
  assign eng_push  = eng_valid && !eng_full_q;

  assign wd_expire = (state_q == S_WAIT) && !LCD_RUN_FINISH && (wdog_q == WD_LAST);

  // CPU FIFO payload write; payload needs no reset since the level gates reads
  always_ff @(posedge clk) begin
    if (cpu_push) mem_q[wr_ptr_q] <= cpu_cmd;
  end

  // CPU FIFO occupancy next-state
  always_comb begin
    level_d = level_q;
    if (cpu_push && !cpu_pop)      level_d = level_q + 1'b1;
    else if (!cpu_push && cpu_pop) level_d = level_q - 1'b1;
  end

  // CPU FIFO pointers and occupancy
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (cpu_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (cpu_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Engine slot payload; a load and a grant never coincide (load needs empty, grant needs full)
  always_ff @(posedge clk) begin
    if (eng_push) eng_cmd_q <= eng_cmd;
  end

  // Engine slot occupancy
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)          eng_full_q <= 1'b0;
    else if (eng_push)  eng_full_q <= 1'b1;
    else if (grant_eng) eng_full_q <= 1'b0;
  end

  // Round-robin grant, only from IDLE with the controller reporting not-finished
  always_comb begin
    grant_cpu = 1'b0;
    grant_eng = 1'b0;
    if (state_q == S_IDLE && !LCD_RUN_FINISH) begin
      if (!cpu_empty && eng_full_q) begin
        if (last_grant_q) grant_cpu = 1'b1;
        else              grant_eng = 1'b1;
      end else if (!cpu_empty) begin
        grant_cpu = 1'b1;
      end else if (eng_full_q) begin
        grant_eng = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_cpu || grant_eng)       state_d = S_WAIT;
      S_WAIT:  if (LCD_RUN_FINISH || wd_expire)  state_d = S_CLEAR;
      S_CLEAR:                                   state_d = S_GAP;
      S_GAP:   if (!LCD_RUN_FINISH)              state_d = S_IDLE;
      default:                                   state_d = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered controller-facing outputs
  always_comb begin
    lcd_reg_d     = lcd_reg_q;
    rstn_en_d     = 1'b1;
    done_pulse_d  = 1'b0;
    done_src_d    = done_src_q;
    last_grant_d  = last_grant_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_cpu) begin
          lcd_reg_d    = {mem_q[rd_ptr_q], 1'b1};
          done_src_d   = 1'b0;
          last_grant_d = 1'b0;
          wdog_d       = '0;
        end else if (grant_eng) begin
          lcd_reg_d    = {eng_cmd_q, 1'b1};
          done_src_d   = 1'b1;
          last_grant_d = 1'b1;
          wdog_d       = '0;
        end
      end
      S_WAIT:  wdog_d = wdog_q + 1'b1;
      S_CLEAR: begin
        // Drop start but keep the command bits visible to the controller
        lcd_reg_d    = {lcd_reg_q[31:1], 1'b0};
        rstn_en_d    = 1'b0;
        done_pulse_d = 1'b1;
      end
      default: ;
    endcase
    // A new expiry outranks a clear request in the same cycle
    if (wd_expire)    timeout_err_d = 1'b1;
    else if (err_clr) timeout_err_d = 1'b0;
  end

  // Registered outputs and arbitration history
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      lcd_reg_q     <= '0;
      rstn_en_q     <= 1'b0;
      done_pulse_q  <= 1'b0;
      done_src_q    <= 1'b0;
      last_grant_q  <= 1'b1;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      lcd_reg_q     <= lcd_reg_d;
      rstn_en_q     <= rstn_en_d;
      done_pulse_q  <= done_pulse_d;
      done_src_q    <= done_src_d;
      last_grant_q  <= last_grant_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign LCD_REG     = lcd_reg_q;
  assign rstn_LCD_en = rstn_en_q;
  assign done_pulse  = done_pulse_q;
  assign done_src    = done_src_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != S_IDLE);
  assign cpu_level   = level_q;

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Testbench for lcd_cmd_sched: directed scenarios plus a randomized run
// scored against a queue-based model of the two request paths.
module tb_lcd_cmd_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        cpu_valid, eng_valid, LCD_RUN_FINISH, err_clr;
  logic [30:0] cpu_cmd, eng_cmd;
  logic        cpu_ready, eng_ready, rstn_LCD_en, busy, done_pulse, done_src, timeout_err;
  logic [31:0] LCD_REG;
  logic [2:0]  cpu_level;

  int n_cmp = 0;
  int n_err = 0;

  lcd_cmd_sched #(.FIFO_DEPTH(DEPTH), .TO_W(4)) dut (
    .clk(clk), .RSTn(RSTn),
    .cpu_valid(cpu_valid), .cpu_cmd(cpu_cmd), .cpu_ready(cpu_ready),
    .eng_valid(eng_valid), .eng_cmd(eng_cmd), .eng_ready(eng_ready),
    .LCD_REG(LCD_REG), .rstn_LCD_en(rstn_LCD_en), .LCD_RUN_FINISH(LCD_RUN_FINISH),
    .busy(busy), .done_pulse(done_pulse), .done_src(done_src),
    .timeout_err(timeout_err), .err_clr(err_clr), .cpu_level(cpu_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    RSTn = 1'b0; cpu_valid = 1'b0; eng_valid = 1'b0; LCD_RUN_FINISH = 1'b0; err_clr = 1'b0;
    cpu_cmd = '0; eng_cmd = '0;
    tick(); tick();
    RSTn = 1'b1;
    tick();
  endtask

  // Acts as the LCD controller for one command: waits for start, completes after dly cycles.
  task automatic serve_one(input int dly, output logic [30:0] cmd, output logic src, output bit ok);
    int t;
    ok = 1'b0; cmd = '0; src = 1'b0; t = 0;
    while (!(LCD_REG[0] && rstn_LCD_en) && t < 200) begin tick(); t++; end
    if (t >= 200) return;
    cmd = LCD_REG[31:1];
    repeat (dly) tick();
    LCD_RUN_FINISH = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!done_pulse && t < 50);
    LCD_RUN_FINISH = 1'b0;
    if (!done_pulse) return;
    src = done_src;
    ok  = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0; cpu_valid = 1'b0; eng_valid = 1'b0; LCD_RUN_FINISH = 1'b0; err_clr = 1'b0;
    cpu_cmd = '0; eng_cmd = '0;
    tick(); tick();
    n_cmp++; if (LCD_REG !== 32'h0) begin n_err++; $display("FAIL rst_lcd_reg: got %h exp 0", LCD_REG); end
    n_cmp++; if (rstn_LCD_en !== 1'b0) begin n_err++; $display("FAIL rst_rstn_en: got %b exp 0", rstn_LCD_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL rst_done_pulse: got %b exp 0", done_pulse); end
    n_cmp++; if (done_src !== 1'b0) begin n_err++; $display("FAIL rst_done_src: got %b exp 0", done_src); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout_err: got %b exp 0", timeout_err); end
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL rst_cpu_ready: got %b exp 1", cpu_ready); end
    n_cmp++; if (eng_ready !== 1'b1) begin n_err++; $display("FAIL rst_eng_ready: got %b exp 1", eng_ready); end
    n_cmp++; if (cpu_level !== 3'd0) begin n_err++; $display("FAIL rst_cpu_level: got %0d exp 0", cpu_level); end
    RSTn = 1'b1;
    #2;
    n_cmp++; if (rstn_LCD_en !== 1'b0) begin n_err++; $display("FAIL rst_rstn_en_pre_edge: got %b exp 0", rstn_LCD_en); end
    tick();
    n_cmp++; if (rstn_LCD_en !== 1'b1) begin n_err++; $display("FAIL rst_rstn_en_rise: got %b exp 1", rstn_LCD_en); end
  endtask

  task automatic test_single();
    apply_reset();
    cpu_valid = 1'b1; cpu_cmd = 31'h1234567;
    tick();
    cpu_valid = 1'b0;
    n_cmp++; if (cpu_level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d exp 1", cpu_level); end
    tick();
    n_cmp++; if (LCD_REG !== 32'h2468ACF) begin n_err++; $display("FAIL single_issue: got %h exp 2468acf", LCD_REG); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b exp 1", busy); end
    repeat (6) tick();
    LCD_RUN_FINISH = 1'b1;
    tick();
    n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL single_early_done: got %b exp 0", done_pulse); end
    tick();
    n_cmp++; if (LCD_REG !== 32'h2468ACE) begin n_err++; $display("FAIL single_clear_reg: got %h exp 2468ace", LCD_REG); end
    n_cmp++; if (rstn_LCD_en !== 1'b0) begin n_err++; $display("FAIL single_clear_en: got %b exp 0", rstn_LCD_en); end
    n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL single_done: got %b exp 1", done_pulse); end
    n_cmp++; if (done_src !== 1'b0) begin n_err++; $display("FAIL single_src: got %b exp 0", done_src); end
    tick();
    n_cmp++; if (rstn_LCD_en !== 1'b1) begin n_err++; $display("FAIL single_en_back: got %b exp 1", rstn_LCD_en); end
    n_cmp++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL single_done_width: got %b exp 0", done_pulse); end
    LCD_RUN_FINISH = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b exp 0", busy); end
    n_cmp++; if (LCD_REG !== 32'h2468ACE) begin n_err++; $display("FAIL single_hold: got %h exp 2468ace", LCD_REG); end
  endtask

  task automatic test_round_robin();
    logic [30:0] c [3];
    logic [30:0] e [2];
    logic [30:0] exp_cmd [5];
    logic        exp_src [5];
    logic [30:0] got_cmd;
    logic        got_src;
    bit          ok;
    c[0] = 31'h0000C0; c[1] = 31'h0000C1; c[2] = 31'h0000C2;
    e[0] = 31'h7E0000; e[1] = 31'h7E0001;
    exp_cmd[0] = c[0]; exp_cmd[1] = e[0]; exp_cmd[2] = c[1]; exp_cmd[3] = e[1]; exp_cmd[4] = c[2];
    exp_src[0] = 1'b0; exp_src[1] = 1'b1; exp_src[2] = 1'b0; exp_src[3] = 1'b1; exp_src[4] = 1'b0;
    apply_reset();
    LCD_RUN_FINISH = 1'b1;   // keeps the scheduler in IDLE while both paths fill
    for (int i = 0; i < 3; i++) begin
      cpu_valid = 1'b1; cpu_cmd = c[i];
      eng_valid = (i == 0); eng_cmd = e[0];
      tick();
    end
    cpu_valid = 1'b0; eng_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_held_idle: got busy=%b exp 0", busy); end
    LCD_RUN_FINISH = 1'b0;
    for (int i = 0; i < 5; i++) begin
      serve_one(i + 1, got_cmd, got_src, ok);
      n_cmp++; if (!ok) begin n_err++; $display("FAIL rr_handshake%0d: got ok=0 exp 1", i); end
      n_cmp++; if (got_cmd !== exp_cmd[i]) begin n_err++; $display("FAIL rr_cmd%0d: got %h exp %h", i, got_cmd, exp_cmd[i]); end
      n_cmp++; if (got_src !== exp_src[i]) begin n_err++; $display("FAIL rr_src%0d: got %b exp %b", i, got_src, exp_src[i]); end
      if (i == 1) begin
        eng_valid = 1'b1; eng_cmd = e[1];
        tick();
        eng_valid = 1'b0;
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [30:0] f [5];
    logic [30:0] got_cmd;
    logic        got_src;
    bit          ok;
    for (int i = 0; i < 5; i++) f[i] = 31'h100 + 31'(i);
    apply_reset();
    eng_valid = 1'b1; eng_cmd = 31'h55AA;
    tick();
    eng_valid = 1'b0;
    tick();
    n_cmp++; if (LCD_REG !== {31'h55AA, 1'b1}) begin n_err++; $display("FAIL full_eng_issue: got %h exp %h", LCD_REG, {31'h55AA, 1'b1}); end
    for (int i = 0; i < 4; i++) begin
      cpu_valid = 1'b1; cpu_cmd = f[i];
      tick();
    end
    n_cmp++; if (cpu_level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d exp 4", cpu_level); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b exp 0", cpu_ready); end
    cpu_cmd = f[4];
    tick(); tick();
    cpu_valid = 1'b0;
    n_cmp++; if (cpu_level !== 3'd4) begin n_err++; $display("FAIL full_refuse: got %0d exp 4", cpu_level); end
    serve_one(0, got_cmd, got_src, ok);
    n_cmp++; if (!ok || got_src !== 1'b1) begin n_err++; $display("FAIL full_eng_retire: got ok=%0d src=%b exp ok=1 src=1", ok, got_src); end
    tick(); tick();
    n_cmp++; if (cpu_level !== 3'd3) begin n_err++; $display("FAIL full_after_pop: got %0d exp 3", cpu_level); end
    n_cmp++; if (cpu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_back: got %b exp 1", cpu_ready); end
    for (int i = 0; i < 4; i++) begin
      serve_one(1, got_cmd, got_src, ok);
      n_cmp++; if (!ok || got_cmd !== f[i]) begin n_err++; $display("FAIL full_drain%0d: got ok=%0d cmd=%h exp ok=1 cmd=%h", i, ok, got_cmd, f[i]); end
    end
    repeat (6) tick();
    n_cmp++; if (LCD_REG[0] !== 1'b0 || cpu_level !== 3'd0) begin n_err++; $display("FAIL full_no_fifth: got start=%b level=%0d exp 0/0", LCD_REG[0], cpu_level); end
  endtask

  task automatic test_watchdog();
    logic [30:0] got_cmd;
    logic        got_src;
    bit          ok;
    apply_reset();
    cpu_valid = 1'b1; cpu_cmd = 31'h0ABC;
    tick();
    cpu_cmd = 31'h0DEF;
    tick();
    cpu_valid = 1'b0;
    n_cmp++; if (LCD_REG !== {31'h0ABC, 1'b1}) begin n_err++; $display("FAIL wd_issue: got %h exp %h", LCD_REG, {31'h0ABC, 1'b1}); end
    repeat (14) tick();
    n_cmp++; if (timeout_err !== 1'b0 || LCD_REG[0] !== 1'b1) begin n_err++; $display("FAIL wd_early: got err=%b start=%b exp 0/1", timeout_err, LCD_REG[0]); end
    tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_expire: got %b exp 1", timeout_err); end
    tick();
    n_cmp++; if (done_pulse !== 1'b1 || LCD_REG[0] !== 1'b0 || rstn_LCD_en !== 1'b0) begin n_err++; $display("FAIL wd_retire: got done=%b start=%b en=%b exp 1/0/0", done_pulse, LCD_REG[0], rstn_LCD_en); end
    tick(); tick();
    n_cmp++; if (LCD_REG !== {31'h0DEF, 1'b1}) begin n_err++; $display("FAIL wd_next_issue: got %h exp %h", LCD_REG, {31'h0DEF, 1'b1}); end
    n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_sticky: got %b exp 1", timeout_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %b exp 0", timeout_err); end
    serve_one(0, got_cmd, got_src, ok);
    n_cmp++; if (!ok || got_cmd !== 31'h0DEF) begin n_err++; $display("FAIL wd_second_retire: got ok=%0d cmd=%h exp ok=1 cmd=0def", ok, got_cmd); end
  endtask

  task automatic test_finish_stuck();
    logic [30:0] got_cmd;
    logic        got_src;
    bit          ok;
    apply_reset();
    cpu_valid = 1'b1; cpu_cmd = 31'h5000;
    tick();
    cpu_cmd = 31'h5001;
    tick();
    cpu_valid = 1'b0;
    LCD_RUN_FINISH = 1'b1;
    tick(); tick();
    n_cmp++; if (done_pulse !== 1'b1) begin n_err++; $display("FAIL stuck_done: got %b exp 1", done_pulse); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (LCD_REG[0] !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL stuck_gap%0d: got start=%b busy=%b exp 0/1", i, LCD_REG[0], busy); end
    end
    LCD_RUN_FINISH = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || LCD_REG[0] !== 1'b0) begin n_err++; $display("FAIL stuck_release: got busy=%b start=%b exp 0/0", busy, LCD_REG[0]); end
    tick();
    n_cmp++; if (LCD_REG !== {31'h5001, 1'b1}) begin n_err++; $display("FAIL stuck_next: got %h exp %h", LCD_REG, {31'h5001, 1'b1}); end
    serve_one(0, got_cmd, got_src, ok);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cpu_valid = 1'b1; cpu_cmd = 31'h6000;
    tick();
    cpu_cmd = 31'h6001; eng_valid = 1'b1; eng_cmd = 31'h6002;
    tick();
    cpu_valid = 1'b0; eng_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1 || cpu_level !== 3'd1 || eng_ready !== 1'b0) begin n_err++; $display("FAIL mid_setup: got busy=%b level=%0d eng_ready=%b exp 1/1/0", busy, cpu_level, eng_ready); end
    #2 RSTn = 1'b0;
    #1;
    n_cmp++; if (LCD_REG !== 32'h0 || rstn_LCD_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_async: got reg=%h en=%b busy=%b exp 0/0/0", LCD_REG, rstn_LCD_en, busy); end
    n_cmp++; if (cpu_level !== 3'd0 || cpu_ready !== 1'b1 || eng_ready !== 1'b1) begin n_err++; $display("FAIL mid_flush: got level=%0d cpu_ready=%b eng_ready=%b exp 0/1/1", cpu_level, cpu_ready, eng_ready); end
    n_cmp++; if (done_pulse !== 1'b0 || done_src !== 1'b0 || timeout_err !== 1'b0) begin n_err++; $display("FAIL mid_status: got done=%b src=%b err=%b exp 0/0/0", done_pulse, done_src, timeout_err); end
    tick();
    RSTn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++; if (done_pulse !== 1'b0 || LCD_REG[0] !== 1'b0) begin n_err++; $display("FAIL mid_after%0d: got done=%b start=%b exp 0/0", i, done_pulse, LCD_REG[0]); end
    end
  endtask

  task automatic test_random();
    logic [30:0] mq_cpu [$];
    logic [30:0] m_eng, exp_cmd;
    bit   m_eng_full, m_last_eng, inflight, inflight_src, pick_eng;
    bit   hs_c, hs_e, prev_start, prev_done;
    int   ctl, cnt, grants, retires;
    apply_reset();
    m_eng = '0; m_eng_full = 0; m_last_eng = 1; inflight = 0; inflight_src = 0;
    prev_done = 0; ctl = 0; cnt = 0; grants = 0; retires = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      n_cmp++; if (cpu_ready !== (mq_cpu.size() < DEPTH)) begin n_err++; $display("FAIL rnd_cpu_ready@%0d: got %b exp %b", cyc, cpu_ready, mq_cpu.size() < DEPTH); end
      n_cmp++; if (eng_ready !== !m_eng_full) begin n_err++; $display("FAIL rnd_eng_ready@%0d: got %b exp %b", cyc, eng_ready, !m_eng_full); end
      n_cmp++; if (cpu_level !== 3'(mq_cpu.size())) begin n_err++; $display("FAIL rnd_level@%0d: got %0d exp %0d", cyc, cpu_level, mq_cpu.size()); end
      cpu_valid = (cyc < 1200) && ($urandom_range(0, 99) < 40);
      cpu_cmd   = 31'($urandom());
      eng_valid = (cyc < 1200) && ($urandom_range(0, 99) < 30);
      eng_cmd   = 31'($urandom());
      hs_c = cpu_valid && (mq_cpu.size() < DEPTH);
      hs_e = eng_valid && !m_eng_full;
      case (ctl)
        0: if (LCD_REG[0] && rstn_LCD_en) begin cnt = $urandom_range(1, 6); ctl = 1; end
        1: if (cnt == 0) begin LCD_RUN_FINISH = 1'b1; ctl = 2; end else cnt--;
        2: if (!rstn_LCD_en) begin cnt = $urandom_range(0, 3); ctl = 3; end
        default: if (cnt == 0) begin LCD_RUN_FINISH = 1'b0; ctl = 0; end else cnt--;
      endcase
      prev_start = LCD_REG[0];
      tick();
      if (!prev_start && LCD_REG[0]) begin
        grants++;
        n_cmp++;
        if (inflight || (mq_cpu.size() == 0 && !m_eng_full)) begin
          n_err++; $display("FAIL rnd_grant@%0d: got start with inflight=%0d cpu=%0d eng=%0d exp no start", cyc, inflight, mq_cpu.size(), m_eng_full);
        end else begin
          pick_eng = m_eng_full && (mq_cpu.size() == 0 || !m_last_eng);
          if (pick_eng) begin exp_cmd = m_eng; m_eng_full = 0; end
          else exp_cmd = mq_cpu.pop_front();
          m_last_eng = pick_eng;
          inflight = 1; inflight_src = pick_eng;
          if (LCD_REG[31:1] !== exp_cmd) begin n_err++; $display("FAIL rnd_cmd@%0d: got %h exp %h", cyc, LCD_REG[31:1], exp_cmd); end
        end
      end
      if (done_pulse) begin
        retires++;
        n_cmp++; if (!inflight || done_src !== inflight_src) begin n_err++; $display("FAIL rnd_done@%0d: got src=%b inflight=%0d exp src=%b inflight=1", cyc, done_src, inflight, inflight_src); end
        n_cmp++; if (prev_done) begin n_err++; $display("FAIL rnd_done_b2b@%0d: got back-to-back pulse exp single", cyc); end
        inflight = 0;
      end
      prev_done = done_pulse;
      if (hs_c) mq_cpu.push_back(cpu_cmd);
      if (hs_e) begin m_eng = eng_cmd; m_eng_full = 1; end
    end
    cpu_valid = 1'b0; eng_valid = 1'b0;
    n_cmp++; if (mq_cpu.size() != 0 || m_eng_full || inflight) begin n_err++; $display("FAIL rnd_drain: got cpu=%0d eng=%0d inflight=%0d exp all empty", mq_cpu.size(), m_eng_full, inflight); end
    n_cmp++; if (grants != retires || grants < 50) begin n_err++; $display("FAIL rnd_counts: got grants=%0d retires=%0d exp equal and >=50", grants, retires); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rnd_timeout: got %b exp 0", timeout_err); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no completion exp finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_watchdog();
    test_finish_stuck();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
